// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } pctrl_state_t;

  // Stall/flush pins of PC and the four pipeline registers.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_NONE   = '0;
  localparam ctrl_out_t CTRL_INIT   = '{pc_stall: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                        mem_wb_flush: 1'b1, default: 1'b0};
  localparam ctrl_out_t CTRL_FREEZE = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1,
                                        ex_mem_stall: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};
  localparam ctrl_out_t CTRL_REDIR  = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
  localparam ctrl_out_t CTRL_LUSE   = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1,
                                        default: 1'b0};

  // A flush on a register overrides a hold on the same register.
  function automatic ctrl_out_t flush_wins(input ctrl_out_t c);
    ctrl_out_t r;
    r = c;
    r.if_id_stall = c.if_id_stall & ~c.if_id_flush;
    r.id_ex_stall = c.id_ex_stall & ~c.id_ex_flush;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RESET_BUBBLES = 3,
  parameter int unsigned MEM_TIMEOUT   = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] luse_cnt,
  output logic [CNT_W-1:0] mwait_cnt
);

  localparam int unsigned BW = (RESET_BUBBLES > 1) ? $clog2(RESET_BUBBLES) : 1;
  localparam int unsigned WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  pctrl_state_t  state_q, state_d;
  logic [BW-1:0] bubble_q, bubble_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          load_use, mem_wait;
  ctrl_out_t     run_ctrl, ctrl;
  logic          run_luse, run_mwait;
  logic          luse_inc, mwait_inc;

  // Hazard detection on the ID/EX operands and the MEM-stage handshake.
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == id_ex_rd)) || (id_use_rs2 && (id_rs2 == id_ex_rd)));
    mem_wait = ex_mem_req && !dmem_ready;
  end

  // Prioritised RUN rules; also reused on the cycle dmem releases a wait.
  always_comb begin
    run_ctrl  = CTRL_NONE;
    run_luse  = 1'b0;
    run_mwait = 1'b0;
    if (mem_wait) begin
      run_ctrl  = CTRL_FREEZE;
      run_mwait = 1'b1;
    end else if (ex_redirect) begin
      run_ctrl = CTRL_REDIR;
    end else if (load_use) begin
      run_ctrl = CTRL_LUSE;
      run_luse = 1'b1;
    end
  end

  // Next-state, counter strobes and stage controls.
  always_comb begin
    state_d   = state_q;
    bubble_d  = bubble_q;
    wait_d    = wait_q;
    err_d     = err_q;
    ctrl      = CTRL_NONE;
    luse_inc  = 1'b0;
    mwait_inc = 1'b0;
    case (state_q)
      INIT: begin
        ctrl = CTRL_INIT;
        if (bubble_q == BW'(RESET_BUBBLES - 1))
          state_d = RUN;
        else
          bubble_d = bubble_q + BW'(1);
      end
      RUN: begin
        ctrl      = run_ctrl;
        luse_inc  = run_luse;
        mwait_inc = run_mwait;
        if (run_mwait) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // Freeze drops in the ready cycle, so normal RUN rules drive it.
          ctrl     = run_ctrl;
          luse_inc = run_luse;
          state_d  = RUN;
          wait_d   = '0;
        end else begin
          ctrl      = CTRL_FREEZE;
          mwait_inc = 1'b1;
          if ((MEM_TIMEOUT != 0) && (wait_q == WW'(MEM_TIMEOUT))) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      ERR: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = INIT;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      bubble_q <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  // Drive the pins with flush taking precedence over hold.
  always_comb begin
    ctrl_out_t c;
    c            = flush_wins(ctrl);
    pc_stall     = c.pc_stall;
    if_id_stall  = c.if_id_stall;
    if_id_flush  = c.if_id_flush;
    id_ex_stall  = c.id_ex_stall;
    id_ex_flush  = c.id_ex_flush;
    ex_mem_stall = c.ex_mem_stall;
    mem_wb_flush = c.mem_wb_flush;
  end

  assign mem_err = err_q;

  sat_counter #(.W(CNT_W)) u_luse_cnt (
    .clk (clk),
    .rst (rst),
    .inc (luse_inc),
    .q   (luse_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mwait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mwait_inc),
    .q   (mwait_cnt)
  );

endmodule
